// File: rtl/sst_plru_multi_if.sv
// sst_plru_multi_if: allocation, touch, flush and perf-counter bundle of the SSID allocator.
interface sst_plru_multi_if #(
    parameter int STORE_SET_COUNT = 64,
    parameter int TOUCH_PORTS = 2,
    parameter int SSID_WIDTH = $clog2(STORE_SET_COUNT)
);
    logic                                   new_SSID_valid;
    logic [SSID_WIDTH-1:0]                  new_SSID;
    logic [TOUCH_PORTS-1:0]                 touch_SSID_valid;
    logic [TOUCH_PORTS-1:0][SSID_WIDTH-1:0] touch_SSID;
    logic                                   flush_valid;
    logic [31:0]                            perf_alloc_count;
    logic [31:0]                            perf_touch_count;

    modport master (
        output new_SSID_valid, touch_SSID_valid, touch_SSID, flush_valid,
        input  new_SSID, perf_alloc_count, perf_touch_count
    );

    modport slave (
        input  new_SSID_valid, touch_SSID_valid, touch_SSID, flush_valid,
        output new_SSID, perf_alloc_count, perf_touch_count
    );
endinterface

// File: rtl/sst_plru_multi.sv
// sst_plru_multi: tree pseudo-LRU SSID allocator with multi-port touch and flush.
// Define SST_PERF_CNT_EN to build the saturating allocation/touch counters.
module sst_plru_multi #(
    parameter int STORE_SET_COUNT = 64,
    parameter int SSID_WIDTH = $clog2(STORE_SET_COUNT),
    parameter int TOUCH_PORTS = 2
) (
    input logic             CLK,
    input logic             nRST,
    sst_plru_multi_if.slave bus
);
    typedef logic [STORE_SET_COUNT-1:1] tree_t;
    typedef logic [SSID_WIDTH-1:0]      ssid_t;

    tree_t plru_tree_q, plru_tree_d;
    ssid_t victim;

    // Heap-indexed walk: node n has children 2n and 2n+1, address MSB decides at the root.
    function automatic tree_t touch(input tree_t tree, input ssid_t s);
        tree_t t;
        ssid_t node;
        ssid_t a;
        t = tree;
        node = ssid_t'(1);
        a = s;
        for (int l = 0; l < SSID_WIDTH; l++) begin
            t[node] = ~a[SSID_WIDTH-1];
            node = ssid_t'({node, a[SSID_WIDTH-1]});
            a = a << 1;
        end
        return t;
    endfunction

    always_comb begin
        ssid_t node;
        victim = '0;
        node = ssid_t'(1);
        for (int l = 0; l < SSID_WIDTH; l++) begin
            victim = ssid_t'({victim, plru_tree_q[node]});
            node = ssid_t'({node, plru_tree_q[node]});
        end
    end

    assign bus.new_SSID = victim;

    // Ports in ascending order, allocation last so it wins on shared nodes.
    always_comb begin
        tree_t work;
        work = plru_tree_q;
        for (int p = 0; p < TOUCH_PORTS; p++)
            work = bus.touch_SSID_valid[p] ? touch(work, bus.touch_SSID[p]) : work;
        work = bus.new_SSID_valid ? touch(work, victim) : work;
        plru_tree_d = bus.flush_valid ? '0 : work;
    end

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) plru_tree_q <= '0;
        else       plru_tree_q <= plru_tree_d;

`ifdef SST_PERF_CNT_EN
    logic [31:0] perf_alloc_count_q, perf_alloc_count_d;
    logic [31:0] perf_touch_count_q, perf_touch_count_d;
    logic [32:0] touch_sum;

    always_comb begin
        touch_sum = {1'b0, perf_touch_count_q} + 33'($countones(bus.touch_SSID_valid));
        perf_alloc_count_d = (bus.flush_valid || !bus.new_SSID_valid || &perf_alloc_count_q)
                           ? perf_alloc_count_q : perf_alloc_count_q + 32'd1;
        perf_touch_count_d = bus.flush_valid ? perf_touch_count_q
                           : touch_sum[32]   ? '1 : touch_sum[31:0];
    end

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            perf_alloc_count_q <= '0;
            perf_touch_count_q <= '0;
        end else begin
            perf_alloc_count_q <= perf_alloc_count_d;
            perf_touch_count_q <= perf_touch_count_d;
        end

    assign bus.perf_alloc_count = perf_alloc_count_q;
    assign bus.perf_touch_count = perf_touch_count_q;
`else
    assign bus.perf_alloc_count = '0;
    assign bus.perf_touch_count = '0;
`endif
endmodule

// File: tb/tb_sst_plru_multi.sv
// tb_sst_plru_multi: directed and randomized checks of the PLRU SSID allocator against a tree model.
module tb_sst_plru_multi;
    localparam int N = 8;
    localparam int W = 3;
    localparam int P = 2;
`ifdef SST_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    sst_plru_multi_if #(.STORE_SET_COUNT(N), .TOUCH_PORTS(P)) bus ();
    sst_plru_multi #(.STORE_SET_COUNT(N), .TOUCH_PORTS(P)) dut (
        .CLK (clk),
        .nRST(nrst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit     m_tree [N];
    longint m_alloc;
    longint m_touch;

    function automatic int m_victim();
        int node = 1;
        int v = 0;
        for (int l = 0; l < W; l++) begin
            v = v * 2 + int'(m_tree[node]);
            node = node * 2 + int'(m_tree[node]);
        end
        return v;
    endfunction

    function automatic void m_touch_ssid(input int s);
        int node = 1;
        for (int l = 0; l < W; l++) begin
            int b = (s >> (W - 1 - l)) & 1;
            m_tree[node] = (b == 0);
            node = node * 2 + b;
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < N; i++) m_tree[i] = 1'b0;
        m_alloc = 0;
        m_touch = 0;
    endfunction

    function automatic void m_step(input bit alloc, input bit [P-1:0] tv, input int t0, input int t1, input bit flush);
        int v;
        if (flush) begin
            for (int i = 0; i < N; i++) m_tree[i] = 1'b0;
            return;
        end
        v = m_victim();
        if (tv[0]) m_touch_ssid(t0);
        if (tv[1]) m_touch_ssid(t1);
        if (alloc) m_touch_ssid(v);
        m_alloc = (m_alloc + int'(alloc) > 64'hFFFFFFFF) ? 64'hFFFFFFFF : m_alloc + int'(alloc);
        m_touch = (m_touch + $countones(tv) > 64'hFFFFFFFF) ? 64'hFFFFFFFF : m_touch + $countones(tv);
    endfunction

    function automatic longint exp_alloc();
        return PERF ? m_alloc : 0;
    endfunction

    function automatic longint exp_touch();
        return PERF ? m_touch : 0;
    endfunction

    task automatic step(input bit alloc, input bit [P-1:0] tv, input int t0, input int t1, input bit flush);
        bus.new_SSID_valid = alloc;
        bus.touch_SSID_valid = tv;
        bus.touch_SSID[0] = W'(t0);
        bus.touch_SSID[1] = W'(t1);
        bus.flush_valid = flush;
        @(posedge clk);
        m_step(alloc, tv, t0, t1, flush);
        #1;
    endtask

    task automatic do_reset();
        bus.new_SSID_valid = 1'b0;
        bus.touch_SSID_valid = '0;
        bus.touch_SSID = '0;
        bus.flush_valid = 1'b0;
        nrst = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        bus.new_SSID_valid = 1'b1;
        bus.touch_SSID_valid = '1;
        bus.touch_SSID = '1;
        bus.flush_valid = 1'b0;
        nrst = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.new_SSID !== W'(0)) begin
            n_bad++;
            $display("FAIL reset_victim: new_SSID=%0d expected 0", bus.new_SSID);
        end
        n_cmp++;
        if (bus.perf_alloc_count !== 32'd0 || bus.perf_touch_count !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_perf: alloc=%0d touch=%0d expected 0/0", bus.perf_alloc_count, bus.perf_touch_count);
        end
        do_reset();
    endtask

    task automatic test_alloc_seq();
        int exp_seq [9] = '{0, 4, 2, 6, 1, 5, 3, 7, 0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (bus.new_SSID !== W'(exp_seq[i])) begin
                n_bad++;
                $display("FAIL alloc_seq[%0d]: new_SSID=%0d expected %0d", i, bus.new_SSID, exp_seq[i]);
            end
            step(1'b1, 2'b00, 0, 0, 1'b0);
        end
    endtask

    task automatic test_touch_redirect();
        do_reset();
        step(1'b0, 2'b01, 0, 5, 1'b0);
        n_cmp++;
        if (bus.new_SSID !== W'(4)) begin
            n_bad++;
            $display("FAIL touch_redirect_0: new_SSID=%0d expected 4", bus.new_SSID);
        end
        step(1'b0, 2'b01, 4, 5, 1'b0);
        n_cmp++;
        if (bus.new_SSID !== W'(2)) begin
            n_bad++;
            $display("FAIL touch_redirect_4: new_SSID=%0d expected 2", bus.new_SSID);
        end
    endtask

    task automatic test_port_priority();
        do_reset();
        step(1'b1, 2'b11, 6, 1, 1'b0);
        n_cmp++;
        if (bus.new_SSID !== W'(4)) begin
            n_bad++;
            $display("FAIL port_priority: new_SSID=%0d expected 4", bus.new_SSID);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b00, 0, 0, 1'b0);
            n_cmp++;
            if (bus.new_SSID !== W'(m_victim())) begin
                n_bad++;
                $display("FAIL port_priority_follow[%0d]: new_SSID=%0d expected %0d", i, bus.new_SSID, m_victim());
            end
        end
    endtask

    task automatic test_duplicates();
        do_reset();
        step(1'b1, 2'b11, 0, 0, 1'b0);
        n_cmp++;
        if (bus.new_SSID !== W'(4)) begin
            n_bad++;
            $display("FAIL duplicates: new_SSID=%0d expected 4", bus.new_SSID);
        end
        step(1'b0, 2'b00, 3, 7, 1'b0);
        n_cmp++;
        if (bus.new_SSID !== W'(4)) begin
            n_bad++;
            $display("FAIL invalid_ports: new_SSID=%0d expected 4", bus.new_SSID);
        end
    endtask

    task automatic test_flush();
        int exp_seq [3] = '{0, 4, 2};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bus.new_SSID !== W'(exp_seq[i])) begin
                n_bad++;
                $display("FAIL flush_pre[%0d]: new_SSID=%0d expected %0d", i, bus.new_SSID, exp_seq[i]);
            end
            step(1'b1, 2'b00, 0, 0, 1'b0);
        end
        step(1'b1, 2'b11, 5, 3, 1'b1);
        n_cmp++;
        if (bus.new_SSID !== W'(0)) begin
            n_bad++;
            $display("FAIL flush_victim: new_SSID=%0d expected 0", bus.new_SSID);
        end
        n_cmp++;
        if (bus.perf_alloc_count !== 32'(PERF ? 3 : 0) || bus.perf_touch_count !== 32'd0) begin
            n_bad++;
            $display("FAIL flush_perf: alloc=%0d touch=%0d expected %0d/0", bus.perf_alloc_count, bus.perf_touch_count, PERF ? 3 : 0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 2'b00, 0, 0, 1'b0);
        #2;
        nrst = 1'b0;
        m_reset();
        #1;
        n_cmp++;
        if (bus.new_SSID !== W'(0)) begin
            n_bad++;
            $display("FAIL async_reset: new_SSID=%0d expected 0", bus.new_SSID);
        end
        bus.new_SSID_valid = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        step(1'b1, 2'b00, 0, 0, 1'b0);
        n_cmp++;
        if (bus.new_SSID !== W'(4)) begin
            n_bad++;
            $display("FAIL async_restart: new_SSID=%0d expected 4", bus.new_SSID);
        end
    endtask

    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 10; i++)
            step(1'b1, 2'b11, int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)), 1'b0);
        n_cmp++;
        if (bus.perf_alloc_count !== 32'(PERF ? 10 : 0)) begin
            n_bad++;
            $display("FAIL perf_alloc: got %0d expected %0d", bus.perf_alloc_count, PERF ? 10 : 0);
        end
        n_cmp++;
        if (bus.perf_touch_count !== 32'(PERF ? 20 : 0)) begin
            n_bad++;
            $display("FAIL perf_touch: got %0d expected %0d", bus.perf_touch_count, PERF ? 20 : 0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 2'($urandom), int'($urandom_range(0, N - 1)),
                 int'($urandom_range(0, N - 1)), $urandom_range(0, 15) == 0);
            n_cmp++;
            if (bus.new_SSID !== W'(m_victim())) begin
                n_bad++;
                $display("FAIL random_victim[%0d]: new_SSID=%0d expected %0d", i, bus.new_SSID, m_victim());
            end
            n_cmp++;
            if (bus.perf_alloc_count !== 32'(exp_alloc()) || bus.perf_touch_count !== 32'(exp_touch())) begin
                n_bad++;
                $display("FAIL random_perf[%0d]: alloc=%0d touch=%0d expected %0d/%0d", i,
                         bus.perf_alloc_count, bus.perf_touch_count, exp_alloc(), exp_touch());
            end
        end
    endtask

    initial begin
        test_reset();
        test_alloc_seq();
        test_touch_redirect();
        test_port_priority();
        test_duplicates();
        test_flush();
        test_async_reset();
        test_perf();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
